acc_sched: RTL and testbench
============================

# acc_sched

Round-robin scheduler that shares one W-bit accumulator datapath among NREQ requesters. Each requester streams a burst of operands with a valid/ready/last handshake. The scheduler grants the datapath to one requester at a time, clears it, accumulates the burst, and presents the tagged sum on a result port. It sits between the sample producers and the single accumulator instance, so no arbitration logic is needed upstream.

## Interface
- NREQ, 4, number of requesters (2..16)
- W, 8, operand and accumulator width
- IDW, $clog2(NREQ), requester-index width
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- req_valid  input  NREQ  operand valid, bit i = requester i
- req_data  input  NREQ*W  operand, slice [i*W +: W] = requester i
- req_last  input  NREQ  marks final operand of a burst
- req_ready  output  NREQ  operand accepted when valid & ready
- res_valid  output  1  result available
- res_data  output  W  accumulated sum of the burst
- res_id  output  IDW  requester that owns the result
- res_ready  input  1  result consumer accepts
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - If any req_valid is high, grant the first set bit at or after rr_ptr, searching upward and wrapping NREQ-1 to 0.
  - Register the grant, clear acc to 0, go to RUN.
  - If no requester is valid, stay in IDLE.
- RUN
  - req_ready[grant] = 1; all other ready bits are 0.
  - Each beat with valid & ready does acc <= acc + data, truncated to W bits (wraps).
  - If the requester drops valid, stall and hold the grant; there is no timeout.
  - A beat with last goes to DONE, and the registered result equals acc + data of that beat.
  - A single-beat burst (last on the first beat) is legal.
- DONE
  - res_valid = 1; res_data and res_id are held stable.
  - On res_ready: rr_ptr <= grant+1 (wrapping), go to IDLE.
- req_ready is decoded combinationally from state and grant. It does not depend on req_valid.
- Operands from non-granted requesters are never accepted. Their valid may stay high indefinitely.
- Fairness: after requester k is served, k has lowest priority in the next arbitration.

## Timing
- Reset values: state IDLE, acc 0, rr_ptr 0, grant 0, req_ready 0, res_valid 0, res_data 0, res_id 0, busy 0.
- Grant latency: req_valid rising in IDLE at cycle t gives req_ready high at t+1.
- Result latency: a last beat accepted at cycle t gives res_valid at t+1.
- Minimum burst turnaround is 3 cycles for a 1-beat burst: IDLE, RUN, DONE, with res_ready already high.
- DONE returns to IDLE. Re-arbitration takes one IDLE cycle even when requesters are waiting.
- rst asserted in any state, including mid-burst or with res_valid high, forces all registers to reset values on that edge. The partial sum is discarded and no result is emitted.

## Configuration
- ACC_SAT_EN
  - Defined: the add saturates at 2^W-1. A sticky sat flag is set when saturation occurs, cleared at grant, and appended as res_data's companion output res_sat (1 bit).
  - Not defined: modulo-2^W add; the res_sat port is absent.

## Structure
- Package acc_sched_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE)
  - default NREQ/W localparams
  - a round-robin pick function (request vector and pointer in, index and found flag out)
- Sub-module acc_core holds the accumulator register:
  - inputs: clk, rst, clr, en, din
  - output: acc
  - the saturation logic under ACC_SAT_EN
- acc_sched contains the FSM, pointer, grant, and result registers only.

## Test plan
- Reset: drive rst for 2 cycles with req_valid=4'b1111. Every output is 0 during reset and in the cycle after rst falls. req_ready rises at the second post-reset edge, with grant 0.
- Single burst, NREQ=4, W=8: requester 1 sends 0xAA, 0xAF, 0xEA(last). Expect res_id=1 and res_data=0x43 (0x59 after the 2nd beat). With ACC_SAT_EN, expect res_data=0xFF and res_sat=1.
- Round-robin: requesters 0 and 2 are continuously valid with 1-beat bursts of 0x01 and 0x02. res_id sequence is 0,2,0,2. Add requester 3 after the first result: the sequence becomes 0,2,3,0.
- Backpressure: hold res_ready=0 for 5 cycles in DONE. res_valid, res_data, and res_id stay stable, and req_ready stays 0. The result is accepted on the first cycle res_ready=1.
- Stall: the granted requester drops valid for 3 cycles mid-burst of 0x10,0x20,0x30(last). Its grant is held, other valid requesters receive no ready, and the result is 0x60.
- Reset mid-burst: assert rst after the 2nd beat. No res_valid appears. The next burst, 0x05(last) from requester 3, yields 0x05, with no residue from the aborted sum.

Source files
------------

// File: rtl/acc_sched_pkg.sv
// acc_sched_pkg: shared types, default sizes and the round-robin picker used
// by the accumulator scheduler (acc_sched) and its datapath (acc_core).
//
// Contents:
//   state_t   - scheduler FSM states (IDLE, RUN, DONE)
//   DEF_NREQ  - default number of requesters
//   DEF_W     - default operand / accumulator width
//   MAX_NREQ  - largest supported requester count (sizes the picker)
//   pick_t    - picker result: index plus found flag
//   rr_pick() - first set request bit at or after a pointer, wrapping at nreq
package acc_sched_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 8;
    localparam int MAX_NREQ = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] idx;
        logic       found;
    } pick_t;

    // Scan offsets 0..nreq-1 from ptr; the first hit wins, so ptr itself has
    // the highest priority and ptr-1 the lowest.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                      input logic [3:0]          ptr,
                                      input int                  nreq);
        pick_t r;
        int    j;
        r = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (i < nreq) begin
                j = int'(ptr) + i;
                if (j >= nreq) j = j - nreq;
                if (!r.found && req[j[3:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[3:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_core.sv
// acc_core: the shared W-bit accumulator register.
//
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   clr      - load zero (start of a new burst); wins over en
//   en       - add din into the accumulator this cycle
//   din      - operand
//   acc      - accumulator value
//   sat      - (only with ACC_SAT_EN) sticky saturation flag, cleared by clr
//
// Build option ACC_SAT_EN: the add clamps at 2^W-1 instead of wrapping.
module acc_core
    import acc_sched_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
`ifdef ACC_SAT_EN
    output logic         sat,
`endif
    output logic [W-1:0] acc
);

    // Returns {overflow, result}; result is clamped when ACC_SAT_EN is set.
    function automatic logic [W:0] add_op(input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef ACC_SAT_EN
        if (s[W]) s[W-1:0] = '1;
`endif
        return s;
    endfunction

    logic [W:0] sum;
    assign sum = add_op(acc, din);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
`ifdef ACC_SAT_EN
            sat <= 1'b0;
`endif
        end else if (clr) begin
            acc <= '0;
`ifdef ACC_SAT_EN
            sat <= 1'b0;
`endif
        end else if (en) begin
            acc <= sum[W-1:0];
`ifdef ACC_SAT_EN
            if (sum[W]) sat <= 1'b1;
`endif
        end
    end

`ifndef ACC_SAT_EN
    // Carry out is simply dropped in the wrapping build.
    logic unused_carry;
    assign unused_carry = sum[W];
`endif

endmodule

// File: rtl/acc_sched.sv
// acc_sched: round-robin scheduler sharing one accumulator among NREQ
// requesters. A granted requester streams a valid/ready/last burst; the sum
// is presented with the requester index on the result port.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   req_valid  - per-requester operand valid
//   req_data   - operands, requester i at [i*W +: W]
//   req_last   - per-requester end-of-burst marker
//   req_ready  - one-hot ready to the granted requester while in RUN
//   res_valid  - result available (DONE)
//   res_data   - burst sum
//   res_sat    - (only with ACC_SAT_EN) burst saturated
//   res_id     - requester that owns the result
//   res_ready  - result consumer accepts
//   busy       - scheduler not idle
//
// Build option ACC_SAT_EN: saturating accumulate plus res_sat output.
module acc_sched
    import acc_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    output logic [W-1:0]      res_data,
`ifdef ACC_SAT_EN
    output logic              res_sat,
`endif
    output logic [IDW-1:0]    res_id,
    input  logic              res_ready,
    output logic              busy
);

    state_t         state;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] rr_ptr;
    pick_t          pick;
    logic [W-1:0]   g_data;
    logic           beat;
    logic           clr;

    assign pick   = rr_pick(MAX_NREQ'(req_valid), 4'(rr_ptr), NREQ);
    assign g_data = req_data[grant*W +: W];
    assign beat   = (state == RUN) && req_valid[grant];
    assign clr    = (state == IDLE) && pick.found;
    assign busy   = (state != IDLE);

    // Upper picker index bits are constant zero for small NREQ.
    logic unused_pick;
    assign unused_pick = ^pick.idx;

    always_comb begin
        req_ready = '0;
        if (state == RUN) req_ready[grant] = 1'b1;
    end

    // The accumulator is not touched in DONE, so it holds the final burst
    // sum for as long as the result waits; it doubles as the result register.
    acc_core #(.W(W)) u_core (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (beat),
        .din (g_data),
`ifdef ACC_SAT_EN
        .sat (res_sat),
`endif
        .acc (res_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick.found) begin
                        grant <= pick.idx[IDW-1:0];
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (beat && req_last[grant]) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_id    <= grant;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        // Served requester drops to lowest priority.
                        rr_ptr    <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_sched.sv
// tb_acc_sched: directed self-checking bench for acc_sched (NREQ=4, W=8).
// Build option ACC_SAT_EN switches the expected sums to saturating values.
module tb_acc_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [1:0]  res_id;
    logic        res_ready;
    logic        busy;
`ifdef ACC_SAT_EN
    logic        res_sat;
`endif

    int total = 0;
    int bad   = 0;

    acc_sched #(.NREQ(4), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
`ifdef ACC_SAT_EN
        .res_sat   (res_sat),
`endif
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        req_data[i*8 +: 8] = v;
    endtask

    task automatic do_reset;
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; res_ready = 1'b0;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 4'b1111; req_last = '0; req_data = '0; res_ready = 1'b0;
        tick;
        tick;
        total++;
        if ({req_ready, res_valid, res_data, res_id, busy} !== '0) begin
            bad++;
            $display("FAIL reset_hold: got ready=%b vld=%b data=%h id=%0d busy=%b, want all 0",
                     req_ready, res_valid, res_data, res_id, busy);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({req_ready, res_valid, res_data, res_id, busy} !== '0) begin
            bad++;
            $display("FAIL reset_release: got ready=%b vld=%b data=%h id=%0d busy=%b, want all 0",
                     req_ready, res_valid, res_data, res_id, busy);
        end
        tick;
        total++;
        if (req_ready !== 4'b0001 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_grant: got ready=%b busy=%b, want 0001 1", req_ready, busy);
        end
    endtask

    task automatic test_single_burst;
        logic [7:0] exp_sum;
`ifdef ACC_SAT_EN
        exp_sum = 8'hFF;
`else
        exp_sum = 8'h43;
`endif
        do_reset;
        req_valid = 4'b0010; set_data(1, 8'hAA);
        tick;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL single_grant: got ready=%b want 0010", req_ready);
        end
        tick;
        set_data(1, 8'hAF);
        tick;
        set_data(1, 8'hEA); req_last = 4'b0010;
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_early_valid: got res_valid=%b want 0", res_valid);
        end
        tick;
        req_valid = '0; req_last = '0;
        total++;
        if (res_valid !== 1'b1 || res_data !== exp_sum || res_id !== 2'd1 || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL single_result: got vld=%b data=%h id=%0d ready=%b, want 1 %h 1 0000",
                     res_valid, res_data, res_id, req_ready, exp_sum);
        end
`ifdef ACC_SAT_EN
        total++;
        if (res_sat !== 1'b1) begin
            bad++;
            $display("FAIL single_sat: got res_sat=%b want 1", res_sat);
        end
`endif
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_accept: got vld=%b busy=%b want 0 0", res_valid, busy);
        end
    endtask

    // add3: requester 3 joins right after the first result is seen.
    task automatic test_round_robin(input bit add3, input logic [7:0] exp_ids);
        int n;
        logic [1:0] id_e;
        logic [7:0] d_e;
        do_reset;
        set_data(0, 8'h01); set_data(2, 8'h02); set_data(3, 8'h03);
        req_valid = 4'b0101; req_last = 4'b1101; res_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick;
            if (res_valid === 1'b1) begin
                id_e = exp_ids[n*2 +: 2];
                d_e  = 8'(id_e) + ((id_e == 2'd0) ? 8'd1 : 8'd0);
                total++;
                if (res_id !== id_e || res_data !== d_e) begin
                    bad++;
                    $display("FAIL rr_result%0d (add3=%0d): got id=%0d data=%h, want id=%0d data=%h",
                             n, add3, res_id, res_data, id_e, d_e);
                end
                if (add3 && n == 0) req_valid = 4'b1101;
                n++;
            end
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL rr_timeout (add3=%0d): got %0d results, want 4", add3, n);
        end
        req_valid = '0; req_last = '0; res_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        do_reset;
        set_data(2, 8'h33); set_data(0, 8'h44);
        req_valid = 4'b0100; req_last = 4'b0100;
        tick;
        tick;
        req_valid = 4'b0101; req_last = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (res_valid !== 1'b1 || res_data !== 8'h33 || res_id !== 2'd2 || req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL bp_hold%0d: got vld=%b data=%h id=%0d ready=%b, want 1 33 2 0000",
                         k, res_valid, res_data, res_id, req_ready);
            end
            tick;
        end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_accept: got res_valid=%b want 0", res_valid);
        end
        // Pointer now sits at 3, so requester 0 wins over 2.
        tick;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL bp_next_grant: got ready=%b want 0001", req_ready);
        end
    endtask

    task automatic test_stall;
        do_reset;
        set_data(0, 8'h10); set_data(1, 8'h77);
        req_valid = 4'b0011;
        tick;
        tick;
        set_data(0, 8'h20);
        tick;
        req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            tick;
            total++;
            if (req_ready !== 4'b0001 || res_valid !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold%0d: got ready=%b vld=%b, want 0001 0", k, req_ready, res_valid);
            end
        end
        req_valid = 4'b0011; set_data(0, 8'h30); req_last = 4'b0001;
        tick;
        req_valid = '0; req_last = '0;
        total++;
        if (res_valid !== 1'b1 || res_data !== 8'h60 || res_id !== 2'd0) begin
            bad++;
            $display("FAIL stall_result: got vld=%b data=%h id=%0d, want 1 60 0", res_valid, res_data, res_id);
        end
    endtask

    task automatic test_reset_mid_burst;
        do_reset;
        set_data(3, 8'h70);
        req_valid = 4'b1000;
        tick;
        tick;
        set_data(3, 8'h71);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0; req_valid = '0;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000 || res_data !== 8'h00) begin
            bad++;
            $display("FAIL midrst_clear: got vld=%b busy=%b ready=%b data=%h, want 0 0 0000 00",
                     res_valid, busy, req_ready, res_data);
        end
        tick;
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_no_result: got res_valid=%b want 0", res_valid);
        end
        set_data(3, 8'h05); req_valid = 4'b1000; req_last = 4'b1000; res_ready = 1'b1;
        tick;
        tick;
        req_valid = '0; req_last = '0;
        total++;
        if (res_valid !== 1'b1 || res_data !== 8'h05 || res_id !== 2'd3) begin
            bad++;
            $display("FAIL midrst_next: got vld=%b data=%h id=%0d, want 1 05 3", res_valid, res_data, res_id);
        end
        tick;
        res_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single_burst;
        test_round_robin(1'b0, {2'd2, 2'd0, 2'd2, 2'd0});
        test_round_robin(1'b1, {2'd0, 2'd3, 2'd2, 2'd0});
        test_backpressure;
        test_stall;
        test_reset_mid_burst;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
